// File: rtl/bus_arbiter_if.sv
// bus_arbiter_if: request/grant bundle between the two bus masters and the arbiter
interface bus_arbiter_if;
    logic m0_req;
    logic m1_req;
    logic m0_grant;
    logic m1_grant;
    modport master (output m0_req, m1_req, input m0_grant, m1_grant);
    modport slave  (input m0_req, m1_req, output m0_grant, m1_grant);
endinterface

// File: rtl/bus_arbiter.sv
// bus_arbiter: two-master non-preemptive arbiter parked on master 0, Moore one-hot grants
module bus_arbiter (
    input logic           clk,
    input logic           reset,
    bus_arbiter_if.slave  bus
);
    localparam logic [1:0] M0_OWN = 2'b01;
    localparam logic [1:0] M1_OWN = 2'b10;
    logic [1:0] state_q;
    logic [1:0] state_d;
    always_comb begin
        state_d = (state_q == M1_OWN) ? (bus.m1_req ? M1_OWN : M0_OWN) :
                  (state_q == M0_OWN) ? ((!bus.m0_req && bus.m1_req) ? M1_OWN : M0_OWN) :
                  M0_OWN;
    end
    always_ff @(posedge clk) begin
        if (reset) state_q <= M0_OWN;
        else       state_q <= state_d;
    end
    // an illegal encoding still yields exactly one grant until it recovers
    assign bus.m1_grant = (state_q == M1_OWN);
    assign bus.m0_grant = ~bus.m1_grant;
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed vectors plus an owner-level reference model checked every cycle
module tb_bus_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   owner = 0;
    bit   valid = 1'b0;
    bit   done = 1'b0;
    bus_arbiter_if bus ();
    bus_arbiter dut (.clk(clk), .reset(reset), .bus(bus.slave));
    always #5 clk = ~clk;
    // reference: owner keeps the bus while requesting, else the other requester takes it, else park on 0
    always @(posedge clk) begin
        logic [1:0] req;
        req = {bus.m1_req, bus.m0_req};
        if (reset) begin
            owner <= 0;
            valid <= 1'b1;
        end else if (valid) begin
            owner <= req[owner] ? owner : req[1 - owner] ? 1 - owner : 0;
        end
    end
    always @(negedge clk) begin
        if (valid && !done) begin
            checks++;
            if (bus.m0_grant !== (owner == 0) || bus.m1_grant !== (owner == 1)) begin
                failures++;
                $display("FAIL model_cmp t=%0t got m0=%b m1=%b expected owner=%0d", $time, bus.m0_grant, bus.m1_grant, owner);
            end
            checks++;
            if ((bus.m0_grant ^ bus.m1_grant) !== 1'b1) begin
                failures++;
                $display("FAIL onehot t=%0t got m0=%b m1=%b required exactly one", $time, bus.m0_grant, bus.m1_grant);
            end
        end
    end
    task automatic cyc(input logic r, input logic a, input logic b);
        reset = r;
        bus.m0_req = a;
        bus.m1_req = b;
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input logic e0, input logic e1, input string name);
        checks++;
        if (bus.m0_grant !== e0 || bus.m1_grant !== e1) begin
            failures++;
            $display("FAIL %s got m0=%b m1=%b expected m0=%b m1=%b", name, bus.m0_grant, bus.m1_grant, e0, e1);
        end
    endtask
    initial begin
        bus.m0_req = 1'b0;
        bus.m1_req = 1'b0;
        @(posedge clk);
        #1;
        cyc(1, 0, 0); chk(1, 0, "reset");
        cyc(0, 0, 0); chk(1, 0, "idle");
        cyc(0, 1, 0); chk(1, 0, "m0_alone1");
        cyc(0, 1, 0); chk(1, 0, "m0_alone2");
        cyc(0, 0, 0); chk(1, 0, "m0_release");
        cyc(0, 0, 1); chk(0, 1, "handover");
        cyc(0, 1, 1); chk(0, 1, "m1_hold1");
        cyc(0, 1, 1); chk(0, 1, "m1_hold2");
        cyc(0, 1, 0); chk(1, 0, "return_m0req");
        cyc(0, 0, 1); chk(0, 1, "handover2");
        cyc(0, 0, 0); chk(1, 0, "return_idle");
        cyc(0, 1, 1); chk(1, 0, "contend_m0");
        cyc(0, 0, 1); chk(0, 1, "to_m1");
        cyc(0, 1, 1); chk(0, 1, "contend_m1");
        cyc(1, 0, 1); chk(1, 0, "reset_mid");
        cyc(0, 0, 1); chk(0, 1, "after_reset");
        cyc(0, 0, 0); chk(1, 0, "park");
        bus.m1_req = 1'b1;
        #2;
        bus.m1_req = 1'b0;
        @(posedge clk);
        #1;
        chk(1, 0, "short_pulse");
        for (int i = 0; i < 60; i++) cyc(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        @(negedge clk);
        #1;
        done = 1'b1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
